// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between NREQ requesters.
// One operation in flight: accept in IDLE, settle in EXEC, hold result in RESP.
module alu_arbiter #(
   parameter int NREQ  = 4,
   parameter int PTR_W = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NREQ-1:0]     req_valid,
   output logic [NREQ-1:0]     req_ready,
   input  logic [NREQ*32-1:0]  req_in0,
   input  logic [NREQ*32-1:0]  req_in1,
   input  logic [NREQ*4-1:0]   req_ctrl,
   output logic [31:0]         alu_in0,
   output logic [31:0]         alu_in1,
   output logic [3:0]          alu_ctrl,
   input  logic [31:0]         alu_res,
   input  logic                alu_zero,
   output logic [NREQ-1:0]     rsp_valid,
   input  logic [NREQ-1:0]     rsp_ready,
   output logic [31:0]         rsp_res,
   output logic                rsp_zero,
   output logic                busy
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t           state, state_nxt;
   logic [PTR_W-1:0] rr_ptr, gnt_id, gnt_sel;
   logic             gnt_found, accept;
   int unsigned      idx;

   // First valid requester at or after rr_ptr, wrapping modulo NREQ.
   always_comb begin
      gnt_found = 1'b0;
      gnt_sel   = '0;
      idx       = 0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         idx = 32'(rr_ptr) + k;
         if (idx >= NREQ) idx = idx - NREQ;
         if (!gnt_found && req_valid[idx[PTR_W-1:0]]) begin
            gnt_found = 1'b1;
            gnt_sel   = idx[PTR_W-1:0];
         end
      end
   end

   assign accept = (state == IDLE) && gnt_found;

   always_comb begin
      state_nxt = state;
      req_ready = '0;
      rsp_valid = '0;
      busy      = (state != IDLE);
      case (state)
         IDLE: begin
            if (gnt_found) begin
               state_nxt = EXEC;
               if (!rst) req_ready[gnt_sel] = 1'b1;
            end
         end
         EXEC: state_nxt = RESP;
         RESP: begin
            rsp_valid[gnt_id] = 1'b1;
            if (rsp_ready[gnt_id]) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr   <= '0;
         gnt_id   <= '0;
         alu_in0  <= '0;
         alu_in1  <= '0;
         alu_ctrl <= '0;
         rsp_res  <= '0;
         rsp_zero <= 1'b0;
      end else begin
         // ALU operands only change on an accept, so the ALU is otherwise quiet.
         if (accept) begin
            alu_in0  <= req_in0[32*gnt_sel +: 32];
            alu_in1  <= req_in1[32*gnt_sel +: 32];
            alu_ctrl <= req_ctrl[4*gnt_sel +: 4];
            gnt_id   <= gnt_sel;
            rr_ptr   <= (gnt_sel == PTR_W'(NREQ-1)) ? '0 : gnt_sel + 1'b1;
         end
         if (state == EXEC) begin
            rsp_res  <= alu_res;
            rsp_zero <= alu_zero;
         end
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus randomized traffic checked
// every cycle against a transaction-level model of the arbiter.
module tb_alu_arbiter;
   localparam int NREQ  = 4;
   localparam int PTR_W = 2;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic [NREQ-1:0]     req_valid = '0;
   logic [NREQ-1:0]     req_ready;
   logic [NREQ*32-1:0]  req_in0 = '0;
   logic [NREQ*32-1:0]  req_in1 = '0;
   logic [NREQ*4-1:0]   req_ctrl = '0;
   logic [31:0]         alu_in0, alu_in1, alu_res, rsp_res;
   logic [3:0]          alu_ctrl;
   logic                alu_zero, rsp_zero, busy;
   logic [NREQ-1:0]     rsp_valid;
   logic [NREQ-1:0]     rsp_ready = '0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   alu_arbiter #(.NREQ(NREQ), .PTR_W(PTR_W)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_in0(req_in0), .req_in1(req_in1), .req_ctrl(req_ctrl),
      .alu_in0(alu_in0), .alu_in1(alu_in1), .alu_ctrl(alu_ctrl),
      .alu_res(alu_res), .alu_zero(alu_zero),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_res(rsp_res), .rsp_zero(rsp_zero), .busy(busy)
   );

   function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                         input logic [3:0] op);
      case (op)
         4'd0: return a + b;
         4'd1: return a - b;
         4'd2: return a & b;
         4'd3: return a | b;
         4'd4: return a ^ b;
         4'd5: return (a < b) ? 32'd1 : 32'd0;
         default: return 32'd0;
      endcase
   endfunction

   assign alu_res  = alu_f(alu_in0, alu_in1, alu_ctrl);
   assign alu_zero = (alu_res == 32'd0);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int pick(input logic [NREQ-1:0] v, input int rr);
      int j;
      for (int k = 0; k < NREQ; k++) begin
         j = (rr + k) % NREQ;
         if (v[j[PTR_W-1:0]]) return j;
      end
      return -1;
   endfunction

   // Transaction model: at most one pending op with its age since accept.
   int               m_rr = 0;
   bit               m_pend = 1'b0;
   logic [PTR_W-1:0] m_id = '0;
   int               m_age = 0;
   int               m_acc = -1;
   logic [31:0]      m_in0 = '0, m_in1 = '0, m_res = '0;
   logic [3:0]       m_ctrl = '0;
   logic             m_zero = 1'b0;

   always @(posedge clk or posedge rst) begin
      int g;
      if (rst) begin
         m_rr = 0; m_pend = 1'b0; m_id = '0; m_age = 0; m_acc = -1;
         m_in0 = '0; m_in1 = '0; m_ctrl = '0; m_res = '0; m_zero = 1'b0;
      end else begin
         m_acc = -1;
         if (!m_pend) begin
            g = pick(req_valid, m_rr);
            if (g >= 0) begin
               m_pend = 1'b1;
               m_id   = g[PTR_W-1:0];
               m_acc  = g;
               m_in0  = req_in0[32*g +: 32];
               m_in1  = req_in1[32*g +: 32];
               m_ctrl = req_ctrl[4*g +: 4];
               m_age  = 1;
               m_rr   = (g + 1) % NREQ;
            end
         end else if (m_age == 1) begin
            m_res  = alu_f(m_in0, m_in1, m_ctrl);
            m_zero = (m_res == 32'd0);
            m_age  = 2;
         end else if (rsp_ready[m_id]) begin
            m_pend = 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      logic [NREQ-1:0] er, ev;
      int g;
      if (!rst) begin
         er = '0;
         ev = '0;
         if (!m_pend) begin
            g = pick(req_valid, m_rr);
            if (g >= 0) er[g[PTR_W-1:0]] = 1'b1;
         end
         if (m_pend && m_age >= 2) ev[m_id] = 1'b1;
         chk("m_req_ready", 32'(req_ready), 32'(er));
         chk("m_rsp_valid", 32'(rsp_valid), 32'(ev));
         chk("m_busy", 32'(busy), 32'(m_pend));
         chk("m_alu_in0", alu_in0, m_in0);
         chk("m_alu_in1", alu_in1, m_in1);
         chk("m_alu_ctrl", 32'(alu_ctrl), 32'(m_ctrl));
         chk("m_rsp_res", rsp_res, m_res);
         chk("m_rsp_zero", 32'(rsp_zero), 32'(m_zero));
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] op);
      req_in0[32*i +: 32] = a;
      req_in1[32*i +: 32] = b;
      req_ctrl[4*i +: 4]  = op;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
      chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
      chk({tag, "_alu_in0"}, alu_in0, 32'd0);
      chk({tag, "_alu_in1"}, alu_in1, 32'd0);
      chk({tag, "_alu_ctrl"}, 32'(alu_ctrl), 32'd0);
      chk({tag, "_rsp_res"}, rsp_res, 32'd0);
      chk({tag, "_rsp_zero"}, 32'(rsp_zero), 32'd0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rr_res [4];
      logic        rr_zero [4];
      int          id;

      repeat (2) @(posedge clk);
      #1;
      chk_reset_vals("rst0");
      rst = 1'b0;

      // Reset then single add
      cyc();
      rsp_ready = 4'b0001;
      set_req(0, 32'd5, 32'd7, 4'd0);
      req_valid = 4'b0001;
      #1;
      chk("t1_req_ready", 32'(req_ready), 32'h1);
      cyc();
      req_valid = 4'b0000;
      chk("t1_alu_in0", alu_in0, 32'd5);
      chk("t1_busy", 32'(busy), 32'd1);
      cyc();
      chk("t1_rsp_valid", 32'(rsp_valid), 32'h1);
      chk("t1_rsp_res", rsp_res, 32'd12);
      chk("t1_rsp_zero", 32'(rsp_zero), 32'd0);
      cyc();
      chk("t1_idle", 32'(busy), 32'd0);

      // Round-robin from a fresh pointer
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      set_req(0, 32'd10, 32'd20, 4'd0);
      set_req(1, 32'hF0F0, 32'h0FF0, 4'd2);
      set_req(2, 32'd3, 32'd3, 4'd1);
      set_req(3, 32'h100, 32'h001, 4'd3);
      rr_res  = '{32'd30, 32'h00F0, 32'd0, 32'h101};
      rr_zero = '{1'b0, 1'b0, 1'b1, 1'b0};
      req_valid = 4'b1111;
      rsp_ready = 4'b1111;
      #1;
      for (int k = 0; k < 5; k++) begin
         id = k % NREQ;
         chk("rr_grant", 32'(req_ready), 32'(4'b0001 << id));
         cyc();
         if (k > 0) req_valid = req_valid & ~(4'b0001 << id);
         cyc();
         chk("rr_rsp_valid", 32'(rsp_valid), 32'(4'b0001 << id));
         chk("rr_rsp_res", rsp_res, rr_res[id]);
         chk("rr_rsp_zero", 32'(rsp_zero), 32'(rr_zero[id]));
         cyc();
      end

      // Response backpressure on req1 while req0 waits
      rsp_ready = 4'b0000;
      set_req(1, 32'hFF, 32'h0F, 4'd4);
      req_valid = 4'b0010;
      #1;
      chk("bp_grant1", 32'(req_ready), 32'h2);
      cyc();
      set_req(0, 32'd1, 32'd2, 4'd0);
      req_valid = 4'b0001;
      #1;
      chk("bp_exec_ready", 32'(req_ready), 32'h0);
      cyc();
      for (int k = 0; k < 5; k++) begin
         chk("bp_rsp_valid", 32'(rsp_valid), 32'h2);
         chk("bp_rsp_res", rsp_res, 32'hF0);
         chk("bp_req_ready", 32'(req_ready), 32'h0);
         cyc();
      end
      rsp_ready = 4'b0010;
      #1;
      chk("bp_last_resp", 32'(rsp_valid), 32'h2);
      chk("bp_last_ready", 32'(req_ready), 32'h0);
      cyc();
      chk("bp_grant0", 32'(req_ready), 32'h1);
      rsp_ready = 4'b1111;
      cyc();
      req_valid = 4'b0000;
      cyc();
      chk("bp_res0", rsp_res, 32'd3);
      cyc();

      // Wrong-requester ready, plus set-less-than
      rsp_ready = 4'b0001;
      set_req(3, 32'd2, 32'd9, 4'd5);
      req_valid = 4'b1000;
      cyc();
      req_valid = 4'b0000;
      cyc();
      for (int k = 0; k < 4; k++) begin
         chk("wr_busy", 32'(busy), 32'd1);
         chk("wr_rsp_valid", 32'(rsp_valid), 32'h8);
         cyc();
      end
      rsp_ready = 4'b1000;
      #1;
      chk("slt_res", rsp_res, 32'd1);
      chk("slt_zero", 32'(rsp_zero), 32'd0);
      cyc();
      chk("wr_idle", 32'(busy), 32'd0);

      // Undefined opcode
      rsp_ready = 4'b0100;
      set_req(2, 32'd7, 32'd3, 4'b1010);
      req_valid = 4'b0100;
      cyc();
      req_valid = 4'b0000;
      cyc();
      chk("bad_rsp_valid", 32'(rsp_valid), 32'h4);
      chk("bad_res", rsp_res, 32'd0);
      chk("bad_zero", 32'(rsp_zero), 32'd1);
      cyc();

      // Asynchronous reset during EXEC
      rsp_ready = 4'b1111;
      set_req(1, 32'd4, 32'd4, 4'd0);
      req_valid = 4'b0010;
      cyc();
      req_valid = 4'b0000;
      #2;
      rst = 1'b1;
      #1;
      chk_reset_vals("arst");
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         cyc();
         chk("arst_no_rsp", 32'(rsp_valid), 32'h0);
      end
      set_req(0, 32'd1, 32'd1, 4'd0);
      set_req(3, 32'd0, 32'd0, 4'd3);
      req_valid = 4'b1001;
      #1;
      chk("arst_grant0", 32'(req_ready), 32'h1);
      cyc();
      req_valid = 4'b1000;

      // Randomized traffic, checked against the model every cycle
      for (int c = 0; c < 900; c++) begin
         cyc();
         if (m_acc >= 0) req_valid = req_valid & ~(4'b0001 << m_acc);
         for (int i = 0; i < NREQ; i++) begin
            if (!req_valid[i[PTR_W-1:0]] && $urandom_range(0, 99) < 35) begin
               logic [31:0] a, b;
               logic [3:0]  op;
               a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 7)) : $urandom();
               b  = ($urandom_range(0, 3) == 0) ? a : $urandom();
               op = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(0, 5))
                                               : 4'($urandom_range(6, 15));
               set_req(i, a, b, op);
               req_valid = req_valid | (4'b0001 << i);
            end
         end
         rsp_ready = 4'($urandom_range(0, 15));
      end

      req_valid = 4'b0000;
      rsp_ready = 4'b1111;
      repeat (5) cyc();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single combinational integer ALU between `NREQ` requesters, such as the execute stage, the address generator and the debug/test port. Each requester presents an operation with a valid/ready handshake. The arbiter grants one requester round-robin, registers the operands onto the ALU inputs for one cycle and captures the result and zero flag. It then returns them to the granted requester with a response valid/ready handshake. Only one operation is in flight at a time.

## Interface
- `NREQ`, default 4: number of requesters (2..8).
- `PTR_W`, default 2: pointer width, equal to ceil(log2(NREQ)).
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: reset, asynchronous and active-high.
- `req_valid` input NREQ: per-requester operation request.
- `req_ready` output NREQ: one-hot accept; an operation is accepted on a cycle where `req_valid[i] & req_ready[i]`.
- `req_in0` input NREQ*32: packed operand 0; requester i uses bits [32i+31:32i].
- `req_in1` input NREQ*32: packed operand 1, same packing.
- `req_ctrl` input NREQ*4: packed 4-bit ALU opcode; requester i uses bits [4i+3:4i].
- `alu_in0`, `alu_in1` output 32: registered operands driven to the ALU.
- `alu_ctrl` output 4: registered opcode driven to the ALU.
- `alu_res` input 32: ALU result (combinational from `alu_in0`/`alu_in1`/`alu_ctrl`).
- `alu_zero` input 1: ALU zero flag.
- `rsp_valid` output NREQ: one-hot; result valid for requester i.
- `rsp_ready` input NREQ: requester i accepts its response.
- `rsp_res` output 32: captured result, shared by all requesters.
- `rsp_zero` output 1: captured zero flag.
- `busy` output 1: high in any state other than IDLE.

## Operation
- The FSM has three states: IDLE, EXEC and RESP.
- **IDLE**
  - The arbiter computes the grant combinationally: the first i with `req_valid[i]`, searching from `rr_ptr` upward modulo NREQ.
  - `req_ready` equals that one-hot grant; it is all-zero outside IDLE or when no request is valid.
  - On accept:
    - `alu_in0`/`alu_in1`/`alu_ctrl` load the granted requester's fields.
    - `gnt_id` is stored.
    - `rr_ptr` becomes `gnt_id + 1`, wrapping to 0 after NREQ-1.
    - The FSM goes to EXEC.
- **EXEC** (exactly 1 cycle)
  - The ALU settles.
  - At the end of the cycle, `alu_res` is captured into `rsp_res` and `alu_zero` into `rsp_zero`.
  - The FSM goes to RESP.
- **RESP**
  - `rsp_valid[gnt_id]` is 1 and all other bits are 0.
  - `rsp_res` and `rsp_zero` are held stable.
  - When `rsp_ready[gnt_id]` is high, the FSM returns to IDLE. `rsp_ready` bits of other requesters are ignored.
- `alu_in0`/`alu_in1`/`alu_ctrl` hold their last values outside load cycles; no spurious ALU activity.
- Opcodes pass through unmodified: 0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 unsigned set-less-than. Other opcodes yield `rsp_res`=0 and `rsp_zero`=1, because the ALU defines them that way.
- `req_valid` must not depend combinationally on `req_ready`. A requester holds its valid and fields stable until accepted.
- A requester may raise `req_valid` while its own response is pending. It is not granted again until the FSM returns to IDLE.

## Timing
- Reset values:
  - FSM state: IDLE.
  - `rr_ptr`, `gnt_id`: 0.
  - `alu_in0`, `alu_in1`, `alu_ctrl`: 0.
  - `rsp_res`: 0.
  - `rsp_zero`: 0.
  - `rsp_valid`, `req_ready`, `busy`: 0.
- Reset asserted mid-operation aborts immediately. The pending response is lost and no `rsp_valid` is issued after reset.
- Latency: accept at cycle T, EXEC at T+1, `rsp_valid` first high at T+2.
- If `rsp_ready` is high at T+2, IDLE is at T+3 and the next accept can happen at T+3.
- Peak throughput is one operation per 3 cycles.
- `req_ready` is combinational from `req_valid`, state and `rr_ptr`. All other outputs are registered or decoded from state.
- Simultaneous requests: exactly one is granted per accept. Fairness: a continuously valid requester is granted within NREQ accepts.
- All-requesters-valid with NREQ=4 gives grant order 0, 1, 2, 3, 0...
- A single requester alone is granted back-to-back, every 3 cycles.

## Test plan
- **Reset then single add:** reset; req0 does in0=5, in1=7, ctrl=0000 at T. Required: `req_ready`=0001 at T; `alu_in0`=5 at T+1; `rsp_valid`=0001, `rsp_res`=12, `rsp_zero`=0 at T+2.
- **Round-robin:** all four valid with distinct ops, `rsp_ready` tied high. Required: grants 0, 1, 2, 3, 0 on accepts 3 cycles apart; each `rsp_res` matches its own op. Use req2 sub 3-3: `rsp_res`=0, `rsp_zero`=1.
- **Response backpressure:** req1 does xor 0xFF^0x0F with `rsp_ready[1]` low for 5 cycles while req0 is valid. Required: `rsp_valid`=0010 and `rsp_res`=0xF0 held stable; `req_ready`=0; req0 is granted only in the cycle after `rsp_ready[1]` rises.
- **Wrong-requester ready:** in RESP for req3, raise `rsp_ready[0]` only. Required: the FSM stays in RESP and `busy`=1.
- **SLT and invalid opcode:** ctrl=0101 with 2<9 gives `rsp_res`=1. ctrl=1010 gives `rsp_res`=0, `rsp_zero`=1.
- **Async reset mid-EXEC:** assert `rst` between edges in EXEC. Required: all outputs go to reset values immediately; no `rsp_valid` after release; the next grant starts from requester 0.
